// File: rtl/mix_scheduler.sv
// mix_scheduler: fetches one backing-track word (plus an optional mic word), mixes them and pushes
// the result to both DAC FIFOs. Optional macro MIX_SATURATE_EN clamps the mix instead of wrapping.
module mix_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int UCNT_W  = 16
) (
    input  logic              audio_clk,
    input  logic              reset_n,
    input  logic              play_in,
    input  logic              fifo_valid_in,
    input  logic [31:0]       fifo_data_in,
    output logic              fifo_ready_out,
    input  logic              adc_valid_in,
    input  logic [31:0]       adc_data_in,
    output logic              adc_ready_out,
    input  logic              dacL_ready_in,
    input  logic              dacR_ready_in,
    output logic              dacL_valid_out,
    output logic              dacR_valid_out,
    output logic [31:0]       dac_data_out,
    output logic [UCNT_W-1:0] underrun_cnt,
    output logic [1:0]        state_out
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MIX   = 2'd2,
        PUSH  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [23:0]       hps_reg;
    logic [23:0]       adc_reg;
    logic              adc_have_reg;
    logic [TW-1:0]     tcount_reg;
    logic [1:0]        dac_valid_reg;
    logic [31:0]       dac_data_reg;
    logic [UCNT_W-1:0] underrun_reg;

    logic [1:0]  dac_ready;
    logic [1:0]  side_done;
    logic        fetch_en;
    logic        adc_fire;
    logic        timeout_hit;
    logic [23:0] adc_term;
    logic [24:0] mix_sum;
    logic [23:0] result24;
    logic        unused_low_bits;

    // Only the upper 24 bits of each word carry audio.
    assign unused_low_bits = ^{fifo_data_in[7:0], adc_data_in[7:0]};

    assign dac_ready = {dacR_ready_in, dacL_ready_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            assign side_done[gi] = !dac_valid_reg[gi] || dac_ready[gi];
        end
    endgenerate

    assign fetch_en    = (state_reg == FETCH) && play_in;
    assign adc_fire    = fetch_en && adc_valid_in && !adc_have_reg;
    assign timeout_hit = (tcount_reg == TW'(TIMEOUT - 1));

    assign fifo_ready_out = fetch_en;
    assign adc_ready_out  = fetch_en && !adc_have_reg;
    assign dacL_valid_out = dac_valid_reg[0];
    assign dacR_valid_out = dac_valid_reg[1];
    assign dac_data_out   = dac_data_reg;
    assign underrun_cnt   = underrun_reg;
    assign state_out      = state_reg;

    always_comb begin
        adc_term = adc_have_reg ? adc_reg : 24'd0;
        mix_sum  = {hps_reg[23], hps_reg} + {adc_term[23], adc_term};
`ifdef MIX_SATURATE_EN
        // Overflow of the 24-bit range shows up as disagreeing top two bits.
        if (mix_sum[24] != mix_sum[23])
            result24 = mix_sum[24] ? 24'h800000 : 24'h7FFFFF;
        else
            result24 = mix_sum[23:0];
`else
        result24 = mix_sum[23:0];
`endif
    end

    always_ff @(posedge audio_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            hps_reg       <= '0;
            adc_reg       <= '0;
            adc_have_reg  <= 1'b0;
            tcount_reg    <= '0;
            dac_valid_reg <= 2'b00;
            dac_data_reg  <= '0;
            underrun_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (play_in)
                        state_reg <= FETCH;
                end
                FETCH: begin
                    if (!play_in) begin
                        state_reg    <= IDLE;
                        adc_have_reg <= 1'b0;
                        tcount_reg   <= '0;
                    end else begin
                        if (adc_fire) begin
                            adc_reg      <= adc_data_in[31:8];
                            adc_have_reg <= 1'b1;
                        end
                        if (fifo_valid_in) begin
                            hps_reg   <= fifo_data_in[31:8];
                            state_reg <= MIX;
                        end else if (timeout_hit) begin
                            hps_reg   <= '0;
                            state_reg <= MIX;
                            if (underrun_reg != '1)
                                underrun_reg <= underrun_reg + 1'b1;
                        end else begin
                            tcount_reg <= tcount_reg + 1'b1;
                        end
                    end
                end
                MIX: begin
                    dac_data_reg  <= {result24, 8'h00};
                    dac_valid_reg <= 2'b11;
                    state_reg     <= PUSH;
                end
                PUSH: begin
                    dac_valid_reg <= dac_valid_reg & ~dac_ready;
                    // play_in is only consulted once the sample has fully left.
                    if (&side_done) begin
                        adc_have_reg <= 1'b0;
                        tcount_reg   <= '0;
                        state_reg    <= play_in ? FETCH : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
